// File: rtl/bcd_time_counter_pkg.sv
// Shared definitions for the BCD time-of-day counter: FSM states,
// edit_field codes and BCD field limits.
package bcd_time_counter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } state_t;

    localparam logic [1:0] FIELD_RUN     = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_H  = 8'h23;

    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping at MAX; carry is high in the cycle an
// increment wraps the field back to 00.
module bcd2_counter
    import bcd_time_counter_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] r_value;
    logic       w_at_max;

    assign w_at_max = (r_value == MAX);
    assign carry    = inc & w_at_max;
    assign value    = r_value;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 8'h00;
        end else if (clr) begin
            r_value <= 8'h00;
        end else if (inc) begin
            if (w_at_max) begin
                r_value <= 8'h00;
            end else if (r_value[3:0] == 4'd9) begin
                r_value <= {r_value[7:4] + 4'd1, 4'd0};
            end else begin
                r_value <= {r_value[7:4], r_value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD clock with a one-second prescaler, two-key time setting
// (mode / increment) and a blink hint for the field being edited.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] seg_bcd,
    output logic        sec_tick,
    output logic [1:0]  edit_field,
    output logic        blink
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [1:0]    w_key_raw;
    logic [1:0]    r_sync1, r_sync2, r_prev, r_armed, r_valid;
    logic [1:0]    w_pulse;
    logic          w_mode_pulse, w_inc_pulse;
    logic [TW-1:0] r_presc;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    state_t        r_state, w_state_next;
    logic          w_run, w_enter_edit;
    logic [7:0]    w_hours, w_minutes, w_seconds;
    logic          w_sec_carry, w_min_carry, w_unused_day_carry;

    assign w_key_raw = {key_inc, key_mode};

    // A key only arms once a genuine low has been sampled after reset, so a
    // key held through reset release cannot produce a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
            r_armed <= 2'b00;
            r_valid <= 2'b00;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= {r_valid[0], 1'b1};
            r_armed <= r_armed | ({2{r_valid[1]}} & ~r_sync2);
        end
    end

    assign w_pulse      = r_sync2 & ~r_prev & r_armed;
    assign w_mode_pulse = w_pulse[KEY_MODE];
    assign w_inc_pulse  = w_pulse[KEY_INC] & ~w_pulse[KEY_MODE];

    assign sec_tick = (r_presc == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (sec_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TW'(1);
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (w_mode_pulse) begin
            case (r_state)
                ST_RUN:   w_state_next = ST_SET_H;
                ST_SET_H: w_state_next = ST_SET_M;
                default:  w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_run        = (r_state == ST_RUN);
    assign w_enter_edit = w_mode_pulse & (r_state != ST_SET_M);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_enter_edit) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (w_state_next == ST_RUN) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Edits never ripple into neighbouring fields: carries only chain in RUN.
    bcd2_counter #(.MAX(BCD_MAX_MS)) u_seconds (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_run & sec_tick),
        .clr   ((r_state == ST_SET_M) & w_mode_pulse),
        .value (w_seconds),
        .carry (w_sec_carry)
    );

    bcd2_counter #(.MAX(BCD_MAX_MS)) u_minutes (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sec_carry | ((r_state == ST_SET_M) & w_inc_pulse)),
        .clr   (1'b0),
        .value (w_minutes),
        .carry (w_min_carry)
    );

    bcd2_counter #(.MAX(BCD_MAX_H)) u_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   ((w_run & w_min_carry) | ((r_state == ST_SET_H) & w_inc_pulse)),
        .clr   (1'b0),
        .value (w_hours),
        .carry (w_unused_day_carry)
    );

    assign seg_bcd    = {w_hours, w_minutes, w_seconds};
    assign edit_field = r_state;
    assign blink      = r_blink;

endmodule
